// File: rtl/alu_muldiv.sv
// RV32I ALU plus iterative RV32M multiply/divide; base ops and special divides finish in 1 cycle, other M ops in WIDTH+2.
// start is honoured only in IDLE; busy covers RUN/CORR, done pulses for one cycle.
module alu_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [4:0]       ALU_func,
  input  logic [WIDTH-1:0] op1,
  input  logic [WIDTH-1:0] op2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] ALU_out
);
  localparam int SHAMT_W = $clog2(WIDTH);

  localparam logic [3:0] F_ADD  = 4'd0;
  localparam logic [3:0] F_SUB  = 4'd1;
  localparam logic [3:0] F_SLL  = 4'd2;
  localparam logic [3:0] F_SLT  = 4'd3;
  localparam logic [3:0] F_SLTU = 4'd4;
  localparam logic [3:0] F_XOR  = 4'd5;
  localparam logic [3:0] F_SRL  = 4'd6;
  localparam logic [3:0] F_SRA  = 4'd7;
  localparam logic [3:0] F_OR   = 4'd8;
  localparam logic [3:0] F_AND  = 4'd9;
  localparam logic [3:0] F_LUI  = 4'd10;

  typedef enum logic [1:0] {IDLE, RUN, CORR, DONE} state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     hi_q, lo_q, dvs_q;
  logic [SHAMT_W-1:0]   cnt_q;
  logic [2:0]           func_q;
  logic                 neg1_q, neg2_q;

  logic [SHAMT_W-1:0]   shamt;
  logic [WIDTH-1:0]     base_res, special_res, corr_res, mag1, mag2;
  logic                 is_m, s1, s2, div_zero, sovf;
  logic [2:0]           m_f;

  assign shamt = op2[SHAMT_W-1:0];
  assign is_m  = ALU_func[4];
  assign m_f   = ALU_func[2:0];

  always_comb begin
    base_res = '0;
    case (ALU_func[3:0])
      F_ADD:   base_res = op1 + op2;
      F_SUB:   base_res = op1 - op2;
      F_SLL:   base_res = op1 << shamt;
      F_SLT:   base_res = {{(WIDTH-1){1'b0}}, $signed(op1) < $signed(op2)};
      F_SLTU:  base_res = {{(WIDTH-1){1'b0}}, op1 < op2};
      F_XOR:   base_res = op1 ^ op2;
      F_SRL:   base_res = op1 >> shamt;
      F_SRA:   base_res = $signed(op1) >>> shamt;
      F_OR:    base_res = op1 | op2;
      F_AND:   base_res = op1 & op2;
      F_LUI:   base_res = op2;
      default: base_res = '0;
    endcase
  end

  // Signedness per funct3: MULH, MULHSU, DIV, REM treat op1 as signed; MULHSU keeps op2 unsigned.
  assign s1       = is_m && (m_f == 3'd1 || m_f == 3'd2 || m_f == 3'd4 || m_f == 3'd6);
  assign s2       = is_m && (m_f == 3'd1 || m_f == 3'd4 || m_f == 3'd6);
  assign mag1     = (s1 && op1[WIDTH-1]) ? -op1 : op1;
  assign mag2     = (s2 && op2[WIDTH-1]) ? -op2 : op2;
  assign div_zero = is_m && m_f[2] && (op2 == {WIDTH{1'b0}});
  assign sovf     = is_m && m_f[2] && !m_f[0] &&
                    (op1 == {1'b1, {(WIDTH-1){1'b0}}}) && (op2 == {WIDTH{1'b1}});

  always_comb begin
    if (div_zero) special_res = m_f[1] ? op1 : {WIDTH{1'b1}};
    else          special_res = m_f[1] ? {WIDTH{1'b0}} : op1;
  end

  // One shift-add multiply step and one restoring divide step on the shared hi/lo pair.
  logic [WIDTH:0]   msum, rshift, rdiff;
  logic [WIDTH-1:0] mul_hi, mul_lo, div_hi, div_lo;

  assign msum   = {1'b0, hi_q} + ({1'b0, dvs_q} & {(WIDTH+1){lo_q[0]}});
  assign mul_hi = msum[WIDTH:1];
  assign mul_lo = {msum[0], lo_q[WIDTH-1:1]};
  assign rshift = {hi_q, lo_q[WIDTH-1]};
  assign rdiff  = rshift - {1'b0, dvs_q};
  assign div_hi = rdiff[WIDTH] ? rshift[WIDTH-1:0] : rdiff[WIDTH-1:0];
  assign div_lo = {lo_q[WIDTH-2:0], ~rdiff[WIDTH]};

  logic [2*WIDTH-1:0] prod, prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  assign prod   = {hi_q, lo_q};
  assign prod_s = (neg1_q ^ neg2_q) ? -prod : prod;
  assign quo_s  = (neg1_q ^ neg2_q) ? -lo_q : lo_q;
  assign rem_s  = neg1_q ? -hi_q : hi_q;

  always_comb begin
    case (func_q)
      3'd0:       corr_res = prod_s[WIDTH-1:0];
      3'd1, 3'd2,
      3'd3:       corr_res = prod_s[2*WIDTH-1:WIDTH];
      3'd4, 3'd5: corr_res = quo_s;
      default:    corr_res = rem_s;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      IDLE: if (start) state_d = (!is_m || div_zero || sovf) ? DONE : RUN;
      RUN: begin
        busy = 1'b1;
        if (cnt_q == '0) state_d = CORR;
      end
      CORR: begin
        busy    = 1'b1;
        state_d = DONE;
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ALU_out <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      func_q  <= '0;
      neg1_q  <= 1'b0;
      neg2_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          if (!is_m)                 ALU_out <= base_res;
          else if (div_zero || sovf) ALU_out <= special_res;
          else begin
            func_q <= m_f;
            neg1_q <= s1 && op1[WIDTH-1];
            neg2_q <= s2 && op2[WIDTH-1];
            cnt_q  <= SHAMT_W'(WIDTH-1);
            hi_q   <= '0;
            lo_q   <= mag1;
            dvs_q  <= mag2;
          end
        end
        RUN: begin
          cnt_q <= cnt_q - SHAMT_W'(1);
          if (func_q[2]) begin
            hi_q <= div_hi;
            lo_q <= div_lo;
          end else begin
            hi_q <= mul_hi;
            lo_q <= mul_lo;
          end
        end
        CORR: ALU_out <= corr_res;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_muldiv.sv
// Randomised and directed checks of alu_muldiv (WIDTH=32 and WIDTH=16) against an arithmetic reference model.
module tb_alu_muldiv;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start, busy, done;
  logic [4:0]  fn;
  logic [31:0] a, b, y;
  logic        start16, busy16, done16;
  logic [4:0]  fn16;
  logic [15:0] a16, b16, y16;

  int nvec = 0;
  int nerr = 0;

  localparam logic [4:0] ADD = 5'h00, SUB = 5'h01, SLL = 5'h02, SLT = 5'h03, SLTU = 5'h04;
  localparam logic [4:0] SRA = 5'h07;
  localparam logic [4:0] MUL = 5'h10, MULH = 5'h11, MULHSU = 5'h12, MULHU = 5'h13;
  localparam logic [4:0] DIV = 5'h14, DIVU = 5'h15, REM = 5'h16, REMU = 5'h17;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .ALU_func(fn), .op1(a), .op2(b),
    .busy(busy), .done(done), .ALU_out(y)
  );

  alu_muldiv #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .start(start16), .ALU_func(fn16), .op1(a16), .op2(b16),
    .busy(busy16), .done(done16), .ALU_out(y16)
  );

  function automatic longint sx(input longint u, input int w);
    return (u >= (longint'(1) << (w-1))) ? u - (longint'(1) << w) : u;
  endfunction

  function automatic logic [31:0] model(input int w, input logic [4:0] f,
                                        input logic [31:0] x, input logic [31:0] z);
    longint mask, ua, ub, sa, sb, r, mn;
    int sh;
    mask = (longint'(1) << w) - 1;
    ua = longint'(x) & mask;
    ub = longint'(z) & mask;
    sa = sx(ua, w);
    sb = sx(ub, w);
    mn = -(longint'(1) << (w-1));
    sh = int'(ub % w);
    r = 0;
    if (f[4]) begin
      case (f[2:0])
        3'd0: r = ua * ub;
        3'd1: r = (sa * sb) >>> w;
        3'd2: r = (sa * ub) >>> w;
        3'd3: r = (ua * ub) >> w;
        3'd4: r = (ub == 0) ? -1 : ((sa == mn && sb == -1) ? sa : sa / sb);
        3'd5: r = (ub == 0) ? -1 : ua / ub;
        3'd6: r = (ub == 0) ? sa : ((sa == mn && sb == -1) ? 0 : sa % sb);
        default: r = (ub == 0) ? ua : ua % ub;
      endcase
    end else begin
      case (f[3:0])
        4'd0:  r = ua + ub;
        4'd1:  r = ua - ub;
        4'd2:  r = ua << sh;
        4'd3:  r = (sa < sb) ? 1 : 0;
        4'd4:  r = (ua < ub) ? 1 : 0;
        4'd5:  r = ua ^ ub;
        4'd6:  r = ua >> sh;
        4'd7:  r = sa >>> sh;
        4'd8:  r = ua | ub;
        4'd9:  r = ua & ub;
        4'd10: r = ub;
        default: r = 0;
      endcase
    end
    r = r & mask;
    return r[31:0];
  endfunction

  function automatic int model_lat(input int w, input logic [4:0] f,
                                   input logic [31:0] x, input logic [31:0] z);
    longint mask, ua, ub;
    mask = (longint'(1) << w) - 1;
    ua = longint'(x) & mask;
    ub = longint'(z) & mask;
    if (!f[4]) return 1;
    if (f[2] && ub == 0) return 1;
    if (f[2] && !f[0] && ua == (longint'(1) << (w-1)) && ub == mask) return 1;
    return w + 2;
  endfunction

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 4))
      0:       return 32'($urandom_range(0, 9));
      1:       return 32'h8000_0000;
      2:       return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [4:0] f, input logic [31:0] x, input logic [31:0] z,
                       output logic [31:0] res, output int lat, output logic bsy);
    fn = f; a = x; b = z; start = 1'b1;
    tick();
    start = 1'b0; a = $urandom; b = $urandom; fn = 5'($urandom);
    lat = 1;
    while (done !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    res = y;
    bsy = busy;
  endtask

  task automatic issue16(input logic [4:0] f, input logic [15:0] x, input logic [15:0] z,
                         output logic [15:0] res, output int lat);
    fn16 = f; a16 = x; b16 = z; start16 = 1'b1;
    tick();
    start16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom);
    lat = 1;
    while (done16 !== 1'b1 && lat < 100) begin
      tick();
      lat++;
    end
    res = y16;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; fn = '0; a = '0; b = '0;
    start16 = 1'b0; fn16 = '0; a16 = '0; b16 = '0;
    tick(); tick();
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL reset_busy got=%b exp=0", busy); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL reset_done got=%b exp=0", done); end
    nvec++; if (y !== 32'h0) begin nerr++; $display("FAIL reset_out got=%h exp=0", y); end
    nvec++; if (y16 !== 16'h0) begin nerr++; $display("FAIL reset_out16 got=%h exp=0", y16); end
    rst = 1'b0;
    tick();
  endtask

  // Directed vectors from a table (with fixed expected results) followed by random vectors vs the model.
  task automatic test_group(input string name, input logic [4:0] df[4], input logic [31:0] da[4],
                            input logic [31:0] db[4], input logic [31:0] de[4], input int dl,
                            input int nrand, input int kind);
    logic [31:0] res, x, z, exp;
    logic [4:0]  f;
    int lat, elat;
    logic bsy;
    for (int i = 0; i < 4 + nrand; i++) begin
      if (i < 4) begin
        f = df[i]; x = da[i]; z = db[i]; exp = de[i]; elat = dl;
      end else begin
        x = pick(); z = pick();
        case (kind)
          0: f = 5'($urandom_range(0, 15));
          1: f = {1'b1, 1'($urandom), 1'b0, 2'($urandom)};
          2: f = {1'b1, 1'($urandom), 1'b1, 2'($urandom)};
          default: begin f = {1'b1, 1'($urandom), 1'b1, 2'($urandom)}; z = 32'h0; end
        endcase
        exp = model(32, f, x, z); elat = model_lat(32, f, x, z);
      end
      issue(f, x, z, res, lat, bsy);
      nvec++;
      if (res !== exp) begin
        nerr++;
        $display("FAIL %s_result f=%h a=%h b=%h got=%h exp=%h", name, f, x, z, res, exp);
      end
      nvec++;
      if (lat !== elat) begin
        nerr++;
        $display("FAIL %s_latency f=%h a=%h b=%h got=%0d exp=%0d", name, f, x, z, lat, elat);
      end
      nvec++;
      if (bsy !== 1'b0) begin nerr++; $display("FAIL %s_busy_at_done got=%b exp=0", name, bsy); end
      tick();
    end
  endtask

  task automatic test_handshake();
    logic [31:0] res, first_y;
    int lat, ndone, first_c, cyc;
    logic bsy, first_b;
    fn = MUL; a = 32'd7; b = 32'hFFFF_FFFD; start = 1'b1;
    tick();
    start = 1'b0; a = $urandom; b = $urandom;
    repeat (4) tick();
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL hs_busy_mid got=%b exp=1", busy); end
    fn = ADD; a = 32'd1; b = 32'd1; start = 1'b1;
    tick();
    start = 1'b0;
    ndone = 0; first_c = 0; first_y = '0; first_b = 1'b1;
    for (cyc = 6; cyc <= 60; cyc++) begin
      if (done === 1'b1) begin
        ndone++;
        if (first_c == 0) begin first_c = cyc; first_y = y; first_b = busy; end
      end
      tick();
    end
    nvec++; if (ndone !== 1) begin nerr++; $display("FAIL hs_done_count got=%0d exp=1", ndone); end
    nvec++; if (first_c !== 34) begin nerr++; $display("FAIL hs_done_cycle got=%0d exp=34", first_c); end
    nvec++; if (first_y !== 32'hFFFF_FFEB) begin nerr++; $display("FAIL hs_result got=%h exp=ffffffeb", first_y); end
    nvec++; if (first_b !== 1'b0) begin nerr++; $display("FAIL hs_busy_at_done got=%b exp=0", first_b); end
    nvec++; if (y !== 32'hFFFF_FFEB) begin nerr++; $display("FAIL hs_out_held got=%h exp=ffffffeb", y); end
    issue(MUL, 32'd3, 32'd5, res, lat, bsy);
    fn = SUB; a = 32'd10; b = 32'd3; start = 1'b1;
    tick();
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL b2b_start_in_done_ignored got=%b exp=0", done); end
    fn = ADD; a = 32'd2; b = 32'd2;
    tick();
    start = 1'b0;
    nvec++; if (done !== 1'b1) begin nerr++; $display("FAIL b2b_done got=%b exp=1", done); end
    nvec++; if (y !== 32'd4) begin nerr++; $display("FAIL b2b_result got=%h exp=4", y); end
    tick();
  endtask

  task automatic test_reset_mid_op();
    logic [31:0] res;
    int lat, ndone;
    logic bsy;
    fn = DIV; a = 32'h1234_5678; b = 32'd3; start = 1'b1;
    tick();
    start = 1'b0;
    repeat (9) tick();
    nvec++; if (busy !== 1'b1) begin nerr++; $display("FAIL rmid_busy_before got=%b exp=1", busy); end
    #1 rst = 1'b1;
    #1;
    nvec++; if (busy !== 1'b0) begin nerr++; $display("FAIL rmid_busy got=%b exp=0", busy); end
    nvec++; if (done !== 1'b0) begin nerr++; $display("FAIL rmid_done got=%b exp=0", done); end
    nvec++; if (y !== 32'h0) begin nerr++; $display("FAIL rmid_out got=%h exp=0", y); end
    tick(); tick();
    rst = 1'b0;
    ndone = 0;
    for (int i = 0; i < 50; i++) begin
      if (done === 1'b1) ndone++;
      tick();
    end
    nvec++; if (ndone !== 0) begin nerr++; $display("FAIL rmid_stray_done got=%0d exp=0", ndone); end
    issue(ADD, 32'd2, 32'd3, res, lat, bsy);
    nvec++; if (res !== 32'd5) begin nerr++; $display("FAIL rmid_add_result got=%h exp=5", res); end
    nvec++; if (lat !== 1) begin nerr++; $display("FAIL rmid_add_latency got=%0d exp=1", lat); end
    tick();
  endtask

  task automatic test_width16();
    logic [15:0] res, x, z, exp;
    logic [31:0] r1, r2, e32;
    logic [4:0]  f;
    int lat;
    issue16(MULH, 16'h8000, 16'h8000, res, lat);
    nvec++; if (res !== 16'h4000) begin nerr++; $display("FAIL w16_mulh got=%h exp=4000", res); end
    nvec++; if (lat !== 18) begin nerr++; $display("FAIL w16_mulh_latency got=%0d exp=18", lat); end
    tick();
    issue16(SLL, 16'h0001, 16'h0013, res, lat);
    nvec++; if (res !== 16'h0008) begin nerr++; $display("FAIL w16_sll got=%h exp=0008", res); end
    nvec++; if (lat !== 1) begin nerr++; $display("FAIL w16_sll_latency got=%0d exp=1", lat); end
    tick();
    for (int i = 0; i < 12; i++) begin
      r1 = pick(); r2 = pick();
      x = r1[15:0]; z = r2[15:0];
      f = (i % 2 == 0) ? {1'b1, 1'($urandom), 3'($urandom)} : 5'($urandom_range(0, 15));
      e32 = model(16, f, {16'h0, x}, {16'h0, z});
      exp = e32[15:0];
      issue16(f, x, z, res, lat);
      nvec++;
      if (res !== exp) begin
        nerr++;
        $display("FAIL w16_rand f=%h a=%h b=%h got=%h exp=%h", f, x, z, res, exp);
      end
      nvec++;
      if (lat !== model_lat(16, f, {16'h0, x}, {16'h0, z})) begin
        nerr++;
        $display("FAIL w16_rand_latency f=%h a=%h b=%h got=%0d", f, x, z, lat);
      end
      tick();
    end
  endtask

  initial begin
    logic [4:0]  df[4];
    logic [31:0] da[4], db[4], de[4];
    test_reset();

    df = '{ADD, SRA, SLT, SLTU};
    da = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    db = '{32'h1, 32'h24, 32'h1, 32'h1};
    de = '{32'h8000_0000, 32'hF800_0000, 32'h1, 32'h0};
    test_group("base", df, da, db, de, 1, 40, 0);

    df = '{MUL, MULH, MULHU, MULHSU};
    da = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    db = '{32'hFFFF_FFFD, 32'h8000_0000, 32'hFFFF_FFFF, 32'd2};
    de = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFFF};
    test_group("mul", df, da, db, de, 34, 12, 1);

    df = '{DIV, REM, DIVU, REMU};
    da = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100};
    db = '{32'd2, 32'd2, 32'd7, 32'd7};
    de = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2};
    test_group("div", df, da, db, de, 34, 12, 2);

    df = '{DIV, REMU, DIV, REM};
    da = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000};
    db = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    de = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'h0};
    test_group("special", df, da, db, de, 1, 8, 3);

    test_handshake();
    test_reset_mid_op();
    test_width16();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
